// File: rtl/dct_pkg.sv
// Shared types and defaults for the DCT stream checker.
// The lane helpers operate on default-sized vectors and are meant for integration code and benches.
package dct_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_W     = 11;
  localparam int DEF_DEPTH = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic [DEF_LANES*DEF_W-1:0] vec_t;
  typedef logic [DEF_W-1:0]           coef_t;

  function automatic coef_t lane_get(input vec_t v, input int k);
    return v[k*DEF_W +: DEF_W];
  endfunction

  function automatic vec_t lane_put(input vec_t v, input int k, input coef_t c);
    vec_t r;
    r = v;
    r[k*DEF_W +: DEF_W] = c;
    return r;
  endfunction

endpackage

// File: rtl/dct_lane_cmp.sv
// Single-lane coefficient compare: exact inequality or signed distance beyond a tolerance.
module dct_lane_cmp #(
  parameter int W = 11
) (
  input  logic         mode,
  input  logic [W-1:0] tol,
  input  logic [W-1:0] data,
  input  logic [W-1:0] gold,
  output logic         mismatch
);

  logic signed [W:0] diff;
  logic        [W:0] mag;

  // One extra bit keeps the difference of two W-bit signed values from wrapping.
  assign diff = $signed({data[W-1], data}) - $signed({gold[W-1], gold});
  assign mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);

  assign mismatch = mode ? (mag > {1'b0, tol}) : (data != gold);

endmodule

// File: rtl/dct_stream_checker.sv
// Streaming checker comparing DCT output vectors against a golden memory, with
// per-group, per-vector and first-failure bookkeeping.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | after reset; golden writes allowed, wait start
// ST_RUN   | accepting vectors, index advances per transfer
// ST_DRAIN | last vector being compared, no new transfers
// ST_DONE  | results stable, golden writes allowed again
module dct_stream_checker
  import dct_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int W      = DEF_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH),
  parameter int GROUPS = 2,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [W-1:0]         tol,
  input  logic                 gold_we,
  input  logic [AW-1:0]        gold_waddr,
  input  logic [LANES*W-1:0]   gold_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  output logic                 busy,
  output logic                 done,
  output logic [GROUPS*CW-1:0] err_grp,
  output logic [CW-1:0]        err_vec_cnt,
  output logic                 first_err_valid,
  output logic [AW-1:0]        first_err_idx,
  output logic [LANES-1:0]     lane_err_mask
);

  localparam int            LPG  = LANES / GROUPS;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t              state, state_nx;
  logic [AW-1:0]       idx, cmp_idx;
  logic                mode_q;
  logic [W-1:0]        tol_q;
  logic [LANES*W-1:0]  gold_mem [DEPTH];
  logic [LANES*W-1:0]  gold_q, data_q;
  logic                cmp_v;
  logic [LANES-1:0]    lane_mis;
  logic [GROUPS-1:0]   grp_mis;
  logic                xfer, idle_like, go;

  assign in_ready  = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign xfer      = in_valid && in_ready;
  assign go        = idle_like && start;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
      ST_RUN:           if (xfer && idx == LAST) state_nx = ST_DRAIN;
      ST_DRAIN:         state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Golden memory and the compare-stage data registers carry no reset.
  always_ff @(posedge clk) begin
    if (gold_we && idle_like) gold_mem[gold_waddr] <= gold_wdata;
    if (xfer) begin
      gold_q <= gold_mem[idx];
      data_q <= in_data;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dct_lane_cmp #(.W(W)) u_cmp (
      .mode     (mode_q),
      .tol      (tol_q),
      .data     (data_q[k*W +: W]),
      .gold     (gold_q[k*W +: W]),
      .mismatch (lane_mis[k])
    );
  end

  always_comb begin
    grp_mis = '0;
    for (int g = 0; g < GROUPS; g++) grp_mis[g] = |lane_mis[g*LPG +: LPG];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      cmp_idx         <= '0;
      mode_q          <= 1'b0;
      tol_q           <= '0;
      cmp_v           <= 1'b0;
      err_grp         <= '0;
      err_vec_cnt     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      lane_err_mask   <= '0;
    end else begin
      cmp_v <= xfer;
      if (go) begin
        idx             <= '0;
        mode_q          <= mode;
        tol_q           <= tol;
        err_grp         <= '0;
        err_vec_cnt     <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
        lane_err_mask   <= '0;
      end else begin
        if (xfer) begin
          idx     <= idx + 1'b1;
          cmp_idx <= idx;
        end
        if (cmp_v) begin
          lane_err_mask <= lane_mis;
          for (int g = 0; g < GROUPS; g++)
            if (grp_mis[g] && err_grp[g*CW +: CW] != CMAX)
              err_grp[g*CW +: CW] <= err_grp[g*CW +: CW] + 1'b1;
          if (|lane_mis) begin
            if (err_vec_cnt != CMAX) err_vec_cnt <= err_vec_cnt + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= cmp_idx;
            end
          end
        end
      end
    end
  end

endmodule
